// File: rtl/card_pkg.sv
// Shared types, constants and helpers for the blackjack round sequencer.
package card_pkg;

    localparam int MAX_CARDS = 9;

    typedef logic [3:0] card_t;
    typedef card_t [0:MAX_CARDS-1] hand_t;

    localparam card_t      CARD_EMPTY   = 4'd0;
    localparam card_t      ACE          = 4'd1;
    localparam card_t      KING         = 4'd13;
    localparam logic [6:0] DEALER_STAND = 7'd17;
    localparam logic [6:0] BLACKJACK    = 7'd21;

    typedef enum logic [1:0] {
        RES_NONE       = 2'd0,
        RES_PLAYER_WIN = 2'd1,
        RES_DEALER_WIN = 2'd2,
        RES_PUSH       = 2'd3
    } result_t;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_DEAL_P0     = 4'd1,
        ST_DEAL_D0     = 4'd2,
        ST_DEAL_P1     = 4'd3,
        ST_DEAL_D1     = 4'd4,
        ST_PLAYER_TURN = 4'd5,
        ST_PLAYER_DRAW = 4'd6,
        ST_DEALER_TURN = 4'd7,
        ST_DEALER_DRAW = 4'd8,
        ST_RESULT      = 4'd9
    } deal_state_t;

    // SETTLE and DONE give the registered scores time to reflect a fresh commit.
    typedef enum logic [1:0] {
        PH_FETCH  = 2'd0,
        PH_WAIT   = 2'd1,
        PH_SETTLE = 2'd2,
        PH_DONE   = 2'd3
    } draw_phase_t;

    function automatic logic card_ok(input card_t v);
        return (v >= ACE) && (v <= KING);
    endfunction

    function automatic result_t round_result(input logic [6:0] p, input logic [6:0] d);
        if (d > BLACKJACK)
            return RES_PLAYER_WIN;
        else if (p > d)
            return RES_PLAYER_WIN;
        else if (p < d)
            return RES_DEALER_WIN;
        else
            return RES_PUSH;
    endfunction

endpackage

// File: rtl/hand_score.sv
// Best blackjack total of one hand: faces count 10, one ace may count 11.
module hand_score
    import card_pkg::*;
(
    input  hand_t      hand,
    output logic [6:0] score
);

    logic [6:0] sum;
    logic       has_ace;

    always_comb begin
        sum     = '0;
        has_ace = 1'b0;
        for (int i = 0; i < MAX_CARDS; i++) begin
            if (hand[i] > 4'd10)
                sum = sum + 7'd10;
            else
                sum = sum + {3'b000, hand[i]};
            if (hand[i] == ACE)
                has_ace = 1'b1;
        end
        score = (has_ace && (sum <= 7'd11)) ? sum + 7'd10 : sum;
    end

endmodule

// File: rtl/card_deal_ctrl.sv
// Sequences one blackjack round and owns both hand arrays; card values land
// in the arrays only on a frame_tick so the renderers never see a torn frame.
module card_deal_ctrl
    import card_pkg::*;
#(
    parameter int unsigned DEAL_DELAY = 6_500_000,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        hit,
    input  logic        stand,
    input  logic        frame_tick,
    input  logic        inject_valid,
    input  logic [3:0]  inject_value,
    output logic [35:0] player_card_values,
    output logic [35:0] dealer_card_values,
    output logic [3:0]  player_count,
    output logic [3:0]  dealer_count,
    output logic [6:0]  player_score,
    output logic [6:0]  dealer_score,
    output logic        busy,
    output logic [1:0]  result,
    output logic [3:0]  state_dbg
);

    localparam logic [15:0] LFSR_MASK  = 16'hB400;
    localparam logic [31:0] DELAY_LAST = 32'(DEAL_DELAY - 1);
    localparam logic [3:0]  MAX_CNT    = 4'(MAX_CARDS);

    deal_state_t state, state_nx;
    draw_phase_t phase, phase_nx;
    result_t     result_q, result_nx;

    logic [15:0] lfsr;
    logic [31:0] delay_cnt;
    logic        first_deal;
    card_t       draw_val;
    card_t       cand;

    hand_t       p_hand, d_hand;
    logic [3:0]  p_cnt, d_cnt;
    logic [6:0]  p_score_c, d_score_c;
    logic [6:0]  p_score_q, d_score_q;

    logic        commit, clear_hands, load_val;
    logic        to_player, delay_ok;

    hand_score u_player_score (.hand(p_hand), .score(p_score_c));
    hand_score u_dealer_score (.hand(d_hand), .score(d_score_c));

    assign cand      = inject_valid ? inject_value : lfsr[3:0];
    assign delay_ok  = first_deal || (delay_cnt >= DELAY_LAST);
    assign to_player = (state == ST_DEAL_P0) || (state == ST_DEAL_P1) ||
                       (state == ST_PLAYER_DRAW);

    // Handshake: start, hit, stand and frame_tick are single-cycle pulses with
    // no back-pressure; a pulse not accepted in the cycle it arrives is dropped.
    always_comb begin
        state_nx    = state;
        phase_nx    = phase;
        result_nx   = result_q;
        commit      = 1'b0;
        clear_hands = 1'b0;
        load_val    = 1'b0;
        unique case (state)
            ST_IDLE, ST_RESULT: begin
                if (start) begin
                    clear_hands = 1'b1;
                    result_nx   = RES_NONE;
                    state_nx    = ST_DEAL_P0;
                    phase_nx    = PH_FETCH;
                end
            end
            ST_PLAYER_TURN: begin
                if (p_score_q == BLACKJACK) begin
                    state_nx = ST_DEALER_TURN;
                end else if (hit && (p_cnt < MAX_CNT)) begin
                    state_nx = ST_PLAYER_DRAW;
                    phase_nx = PH_FETCH;
                end else if (stand || (p_cnt == MAX_CNT)) begin
                    state_nx = ST_DEALER_TURN;
                end
            end
            ST_DEALER_TURN: begin
                if ((d_score_q < DEALER_STAND) && (d_cnt < MAX_CNT)) begin
                    state_nx = ST_DEALER_DRAW;
                    phase_nx = PH_FETCH;
                end else begin
                    state_nx  = ST_RESULT;
                    result_nx = round_result(p_score_q, d_score_q);
                end
            end
            default: begin
                unique case (phase)
                    PH_FETCH: begin
                        if (card_ok(cand)) begin
                            load_val = 1'b1;
                            phase_nx = PH_WAIT;
                        end
                    end
                    PH_WAIT: begin
                        if (frame_tick && delay_ok) begin
                            commit   = 1'b1;
                            phase_nx = PH_SETTLE;
                        end
                    end
                    PH_SETTLE: phase_nx = PH_DONE;
                    PH_DONE: begin
                        phase_nx = PH_FETCH;
                        unique case (state)
                            ST_DEAL_P0: state_nx = ST_DEAL_D0;
                            ST_DEAL_D0: state_nx = ST_DEAL_P1;
                            ST_DEAL_P1: state_nx = ST_DEAL_D1;
                            ST_DEAL_D1: state_nx = ST_PLAYER_TURN;
                            ST_PLAYER_DRAW: begin
                                if (p_score_q > BLACKJACK) begin
                                    state_nx  = ST_RESULT;
                                    result_nx = RES_DEALER_WIN;
                                end else begin
                                    state_nx = ST_PLAYER_TURN;
                                end
                            end
                            default: state_nx = ST_DEALER_TURN;
                        endcase
                    end
                    default: phase_nx = PH_FETCH;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            phase      <= PH_FETCH;
            result_q   <= RES_NONE;
            lfsr       <= LFSR_SEED;
            delay_cnt  <= '0;
            first_deal <= 1'b0;
            draw_val   <= CARD_EMPTY;
            p_score_q  <= '0;
            d_score_q  <= '0;
        end else begin
            state     <= state_nx;
            phase     <= phase_nx;
            result_q  <= result_nx;
            lfsr      <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
            p_score_q <= p_score_c;
            d_score_q <= d_score_c;
            if (load_val)
                draw_val <= cand;
            // Saturates so a long idle period cannot wrap and re-arm the wait.
            if (commit)
                delay_cnt <= '0;
            else if (delay_cnt < DELAY_LAST)
                delay_cnt <= delay_cnt + 32'd1;
            if (clear_hands)
                first_deal <= 1'b1;
            else if (commit)
                first_deal <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_hands) begin
            for (int i = 0; i < MAX_CARDS; i++) begin
                p_hand[i] <= CARD_EMPTY;
                d_hand[i] <= CARD_EMPTY;
            end
            p_cnt <= '0;
            d_cnt <= '0;
        end else if (commit) begin
            if (to_player) begin
                for (int i = 0; i < MAX_CARDS; i++)
                    if (p_cnt == 4'(i))
                        p_hand[i] <= draw_val;
                p_cnt <= p_cnt + 4'd1;
            end else begin
                for (int i = 0; i < MAX_CARDS; i++)
                    if (d_cnt == 4'(i))
                        d_hand[i] <= draw_val;
                d_cnt <= d_cnt + 4'd1;
            end
        end
    end

    // Slot 0 sits in the least significant nibble.
    for (genvar g = 0; g < MAX_CARDS; g++) begin : g_slots
        assign player_card_values[4*g +: 4] = p_hand[g];
        assign dealer_card_values[4*g +: 4] = d_hand[g];
    end

    assign player_count = p_cnt;
    assign dealer_count = d_cnt;
    assign player_score = p_score_q;
    assign dealer_score = d_score_q;
    assign busy         = (state != ST_IDLE) && (state != ST_RESULT);
    assign result       = result_q;
    assign state_dbg    = state;

endmodule
